// File: rtl/garage_ctrl_param.sv
// garage_ctrl_param: parametrised garage controller with timed entry/exit doors and occupancy tracking
//   Clk, Reset (async, active-high)
//   Car_entry_request / Car_exit_request : level requests from the gate sensors
//   Open_entry_door / Open_exit_door     : registered door actuator outputs
//   Garage_is_complete / Garage_is_empty : decoded from the registered Car_count
//   Entry_denied                         : registered, entry request blocked by a full garage
//   Car_count                            : current occupancy

module garage_door #(
    parameter int DOOR_OPEN_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant,
    output logic door,
    output logic idle
);
    localparam int TW = $clog2(DOOR_OPEN_CYCLES + 1);
    localparam logic [TW-1:0] TLOAD = TW'(DOOR_OPEN_CYCLES);
    typedef enum logic [1:0] {IDLE, OPEN, CLOSING} state_t;
    state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            door  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            door  <= state_n == OPEN;
        end
    end
    // timer counts the remaining open cycles; leaving OPEN when it reaches 1 gives exactly DOOR_OPEN_CYCLES
    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            IDLE: begin
                state_n = grant ? OPEN : IDLE;
                timer_n = grant ? TLOAD : timer;
            end
            OPEN: begin
                state_n = timer == TW'(1) ? CLOSING : OPEN;
                timer_n = timer - TW'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    assign idle = state == IDLE;
endmodule

module garage_ctrl_param #(
    parameter int CAPACITY         = 8,
    parameter int DOOR_OPEN_CYCLES = 4,
    localparam int CNT_W           = $clog2(CAPACITY + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Car_entry_request,
    input  logic             Car_exit_request,
    output logic             Open_entry_door,
    output logic             Open_exit_door,
    output logic             Garage_is_complete,
    output logic             Garage_is_empty,
    output logic             Entry_denied,
    output logic [CNT_W-1:0] Car_count
);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    logic entry_idle, exit_idle, entry_grant, exit_grant;
    // both grants use the pre-edge count, so at full only the exit can be granted
    assign entry_grant = entry_idle && Car_entry_request && Car_count < CAP;
    assign exit_grant  = exit_idle && Car_exit_request && Car_count != '0;
    garage_door #(.DOOR_OPEN_CYCLES(DOOR_OPEN_CYCLES)) u_entry (
        .clk(Clk), .rst(Reset), .grant(entry_grant), .door(Open_entry_door), .idle(entry_idle)
    );
    garage_door #(.DOOR_OPEN_CYCLES(DOOR_OPEN_CYCLES)) u_exit (
        .clk(Clk), .rst(Reset), .grant(exit_grant), .door(Open_exit_door), .idle(exit_idle)
    );
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Car_count    <= '0;
            Entry_denied <= 1'b0;
        end else begin
            Car_count    <= (entry_grant && !exit_grant) ? Car_count + CNT_W'(1) :
                            (exit_grant && !entry_grant) ? Car_count - CNT_W'(1) : Car_count;
            Entry_denied <= entry_idle && Car_entry_request && Car_count == CAP;
        end
    end
    assign Garage_is_complete = Car_count == CAP;
    assign Garage_is_empty    = Car_count == '0;
endmodule

// File: tb/tb_garage_ctrl_param.sv
module tb_garage_ctrl_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ent = 1'b0;
    logic ext = 1'b0;
    logic door_e, door_x, full, empty, denied;
    logic [2:0] count;
    int checks = 0;
    int failures = 0;

    garage_ctrl_param #(.CAPACITY(4), .DOOR_OPEN_CYCLES(3)) dut (
        .Clk(clk), .Reset(rst), .Car_entry_request(ent), .Car_exit_request(ext),
        .Open_entry_door(door_e), .Open_exit_door(door_x), .Garage_is_complete(full),
        .Garage_is_empty(empty), .Entry_denied(denied), .Car_count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic admit_entry;
        ent = 1'b1;
        tick();
        ent = 1'b0;
        repeat (4) tick();
    endtask

    task automatic admit_exit;
        ext = 1'b1;
        tick();
        ext = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_door_e", door_e, 0);
        chk("rst_door_x", door_x, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_denied", denied, 0);
        // fill: pulses of 3, spaced 5 apart
        rst = 1'b0;
        ent = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("fill_open", door_e, 1);
            chk("fill_count", count, c);
            chk("fill_full", full, c == 4 ? 1 : 0);
            tick();
            chk("fill_open2", door_e, 1);
            tick();
            chk("fill_open3", door_e, 1);
            tick();
            chk("fill_closing", door_e, 0);
            tick();
            chk("fill_idle", door_e, 0);
        end
        chk("fill_denied_idle", denied, 0);
        tick();
        chk("fill_denied", denied, 1);
        chk("fill_full_hold", full, 1);
        repeat (3) begin
            tick();
            chk("fill_no_pulse", door_e, 0);
            chk("fill_count_hold", count, 4);
        end
        // drain
        ent = 1'b0;
        ext = 1'b1;
        for (int c = 3; c >= 0; c--) begin
            tick();
            chk("drain_open", door_x, 1);
            chk("drain_count", count, c);
            if (c == 3) chk("drain_denied_clr", denied, 0);
            tick();
            chk("drain_open2", door_x, 1);
            tick();
            chk("drain_open3", door_x, 1);
            tick();
            chk("drain_closing", door_x, 0);
            tick();
        end
        chk("drain_empty", empty, 1);
        // exit at empty held for 10 cycles
        repeat (10) begin
            tick();
            chk("empty_exit_door", door_x, 0);
            chk("empty_count", count, 0);
        end
        ext = 1'b0;
        // simultaneous at mid-occupancy
        admit_entry();
        admit_entry();
        chk("mid_pre_count", count, 2);
        ent = 1'b1;
        ext = 1'b1;
        tick();
        chk("mid_door_e", door_e, 1);
        chk("mid_door_x", door_x, 1);
        chk("mid_count", count, 2);
        ent = 1'b0;
        ext = 1'b0;
        repeat (4) tick();
        // simultaneous at full
        admit_entry();
        admit_entry();
        chk("full_pre_count", count, 4);
        ent = 1'b1;
        ext = 1'b1;
        tick();
        chk("full_door_x", door_x, 1);
        chk("full_door_e", door_e, 0);
        chk("full_count", count, 3);
        chk("full_denied", denied, 1);
        ext = 1'b0;
        tick();
        chk("full_entry_late", door_e, 1);
        chk("full_count_back", count, 4);
        chk("full_denied_clr", denied, 0);
        ent = 1'b0;
        repeat (5) tick();
        // reset during the second cycle of an entry opening
        admit_exit();
        admit_exit();
        chk("rm_pre_count", count, 2);
        ent = 1'b1;
        tick();
        chk("rm_open", door_e, 1);
        chk("rm_count3", count, 3);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rm_async_door", door_e, 0);
        chk("rm_async_count", count, 0);
        chk("rm_async_empty", empty, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("rm_regrant", door_e, 1);
        chk("rm_count1", count, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
